// File: rtl/pulse_cdc_sched.sv
// Shares one toggle-handshake pulse crossing (clka -> clkb) among N_REQ requesters.
// Bursts are absorbed by saturating per-requester counters; a round-robin arbiter launches one event at a time.
module pulse_cdc_sched #(
  parameter  int N_REQ = 4,
  parameter  int CNT_W = 4,
  localparam int ID_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic             clka,
  input  logic             clkb,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_a,
  output logic             busy_a,
  output logic             pend_any_a,
  output logic [N_REQ-1:0] ovf_a,
  output logic             evt_valid_b,
  output logic [ID_W-1:0]  evt_id_b
);

  localparam int SW = ID_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   rr_reg;
  logic [ID_W-1:0]   id_hold_reg;
  logic              req_tgl_reg;
  logic              ack_s1_reg, ack_s2_reg;
  logic              pend_any_reg;
  logic [N_REQ-1:0]  nz;
  logic [N_REQ-1:0]  nz_next;
  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [SW-1:0]     scan_idx;
  logic              grant;

  logic              rq_s1_reg, rq_s2_reg, rq_s3_reg;
  logic              evt_valid_reg;
  logic [ID_W-1:0]   evt_id_reg;

  // Per-requester pending counter; a same-cycle pulse and grant cancel out.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ovf_reg, ovf_set, inc, dec;

    assign inc = req_a[gi];
    assign dec = grant && (win_id == ID_W'(gi));

    always_comb begin
      cnt_next = cnt_reg;
      ovf_set  = 1'b0;
      if (inc && !dec) begin
        if (cnt_reg == CNT_MAX) ovf_set  = 1'b1;
        else                    cnt_next = cnt_reg + 1'b1;
      end else if (dec && !inc) begin
        cnt_next = cnt_reg - 1'b1;
      end
    end

    always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= '0;
        ovf_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_next;
        if (ovf_set) ovf_reg <= 1'b1;
      end
    end

    assign nz[gi]      = |cnt_reg;
    assign nz_next[gi] = |cnt_next;
    assign ovf_a[gi]   = ovf_reg;
  end

  // Round-robin search starting one past the last granted index.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = {1'b0, rr_reg} + SW'(k);
      if (scan_idx >= SW'(N_REQ)) scan_idx = scan_idx - SW'(N_REQ);
      if (!win_found && nz[scan_idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = scan_idx[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:     if (win_found) state_next = WAIT_ACK;
      WAIT_ACK: if (ack_s2_reg == req_tgl_reg) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_a = (state_reg == WAIT_ACK);
    grant  = (state_reg == IDLE) && win_found;
  end

  // id_hold only changes at launch, so it is stable whenever clkb samples it.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      rr_reg       <= ID_W'(N_REQ - 1);
      id_hold_reg  <= '0;
      req_tgl_reg  <= 1'b0;
      ack_s1_reg   <= 1'b0;
      ack_s2_reg   <= 1'b0;
      pend_any_reg <= 1'b0;
    end else begin
      ack_s1_reg   <= rq_s3_reg;
      ack_s2_reg   <= ack_s1_reg;
      pend_any_reg <= |nz_next;
      if (grant) begin
        rr_reg      <= win_id;
        id_hold_reg <= win_id;
        req_tgl_reg <= ~req_tgl_reg;
      end
    end
  end

  assign pend_any_a = pend_any_reg;

  // Delivery side: rq_s3 doubles as the acknowledge toggle returned to clka.
  always_ff @(posedge clkb or negedge rst_n) begin
    if (!rst_n) begin
      rq_s1_reg     <= 1'b0;
      rq_s2_reg     <= 1'b0;
      rq_s3_reg     <= 1'b0;
      evt_valid_reg <= 1'b0;
      evt_id_reg    <= '0;
    end else begin
      rq_s1_reg     <= req_tgl_reg;
      rq_s2_reg     <= rq_s1_reg;
      rq_s3_reg     <= rq_s2_reg;
      evt_valid_reg <= rq_s2_reg ^ rq_s3_reg;
      if (rq_s2_reg ^ rq_s3_reg) evt_id_reg <= id_hold_reg;
    end
  end

  assign evt_valid_b = evt_valid_reg;
  assign evt_id_b    = evt_id_reg;

endmodule

// File: tb/tb_pulse_cdc_sched.sv
// Scoreboarded bench for pulse_cdc_sched: stimulus pushes expected ids, a clkb monitor pops and compares.
module tb_pulse_cdc_sched;
  logic       clka = 1'b0;
  logic       clkb = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_a = '0;
  logic       busy_a, pend_any_a, evt_valid_b;
  logic [3:0] ovf_a;
  logic [1:0] evt_id_b;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int mon_exp;

  pulse_cdc_sched #(.N_REQ(4), .CNT_W(4)) dut (
    .clka(clka), .clkb(clkb), .rst_n(rst_n), .req_a(req_a),
    .busy_a(busy_a), .pend_any_a(pend_any_a), .ovf_a(ovf_a),
    .evt_valid_b(evt_valid_b), .evt_id_b(evt_id_b)
  );

  // clka rises at 10k+5 ns, clkb at 40m+20 ns: edges never coincide.
  always #5  clka = ~clka;
  always #20 clkb = ~clkb;

  always @(negedge clkb) begin
    if (rst_n && evt_valid_b) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_evt: got id %0d, required no event", evt_id_b);
      end else begin
        mon_exp = exp_q.pop_front();
        if (int'(evt_id_b) != mon_exp) begin
          fails++;
          $display("[TB] FAIL evt_id: got %0d, required %0d", evt_id_b, mon_exp);
        end else begin
          $display("[TB] delivered id %0d ok", evt_id_b);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    end else begin
      $display("[TB] %s = %0d ok", name, act);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  int'(busy_a), 0);
    check({tag, "_pend"},  int'(pend_any_a), 0);
    check({tag, "_ovf"},   int'(ovf_a), 0);
    check({tag, "_valid"}, int'(evt_valid_b), 0);
    check({tag, "_id"},    int'(evt_id_b), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clka);
    @(negedge clka);
    rst_n = 1'b1;
  endtask

  // Leaves us 1 ns after a clka edge; the next clka edge (edge 0) sits at 15 ns mod 40 after a clkb edge.
  task automatic align();
    @(posedge clkb);
    @(posedge clka);
    #1;
  endtask

  task automatic pulse(input logic [3:0] v);
    req_a = v;
    @(posedge clka);
    #1;
    req_a = '0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy_a || pend_any_a) && n < 3000) begin
      @(posedge clka);
      #1;
      n++;
    end
    repeat (12) @(posedge clkb);
    #1;
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_busy"}, int'(busy_a), 0);
    check({name, "_pend"}, int'(pend_any_a), 0);
  endtask

  initial begin
    repeat (3) @(posedge clka);
    #1;
    check_all_zero("reset");
    @(negedge clka);
    rst_n = 1'b1;

    // Single event from requester 2.
    align();
    exp_q.push_back(2);
    pulse(4'b0100);
    drain("single");
    check("single_ovf", int'(ovf_a), 0);

    // All four at once, rr starts at 3 so order is 0,1,2,3.
    do_reset();
    align();
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    pulse(4'b1111);
    drain("simul");

    // Fairness: grants land on edges 1,14,26,38 -> ids 1,3,1,1; cnt[1] is saturated at 15 when pulses stop.
    do_reset();
    align();
    exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(1); exp_q.push_back(1);
    for (int i = 0; i < 15; i++) exp_q.push_back(1);
    for (int k = 0; k < 40; k++) begin
      req_a = (k == 5) ? 4'b1010 : 4'b0010;
      @(posedge clka);
      #1;
    end
    req_a = '0;
    drain("fair");
    check("fair_ovf", int'(ovf_a), 4'b0010);

    // Saturation: 20 pulses, grants at edges 1 and 14 fall inside the burst, then 15 counted -> 17 deliveries.
    do_reset();
    align();
    for (int i = 0; i < 17; i++) exp_q.push_back(0);
    req_a = 4'b0001;
    repeat (20) begin
      @(posedge clka);
      #1;
    end
    req_a = '0;
    check("sat_ovf_set", int'(ovf_a), 4'b0001);
    drain("sat");
    check("sat_ovf_sticky", int'(ovf_a), 4'b0001);

    // Pulse on requester 2 exactly as it is granted with cnt=1: a second delivery must follow.
    do_reset();
    align();
    exp_q.push_back(2); exp_q.push_back(2);
    req_a = 4'b0100;
    @(posedge clka);
    #1;
    @(posedge clka);
    #1;
    req_a = '0;
    check("samecyc_busy", int'(busy_a), 1);
    check("samecyc_pend", int'(pend_any_a), 1);
    drain("samecyc");

    // Reset mid-flight with 5 events outstanding; nothing may be delivered.
    do_reset();
    align();
    req_a = 4'b1111;
    @(posedge clka);
    #1;
    req_a = 4'b0001;
    @(posedge clka);
    #1;
    req_a = '0;
    check("midrst_busy_before", int'(busy_a), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst_in");
    repeat (3) @(posedge clka);
    @(negedge clka);
    rst_n = 1'b1;
    repeat (20) @(posedge clkb);
    #1;
    check_all_zero("midrst_after");
    align();
    exp_q.push_back(1);
    pulse(4'b0010);
    drain("midrst_new");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
